// File: rtl/ring_pkg.sv
// Shared definitions for the router slot buffer: slot geometry, packet type and
// the output-register state encoding used by the drain.
package ring_pkg;

    localparam int BUFFER_SIZE = 4;
    localparam int PACKET_SIZE = 49;
    localparam int PTR_LEN     = 2;
    localparam int VALID_BIT   = PACKET_SIZE - 1;

    typedef logic [PACKET_SIZE-1:0] packet_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_HOLD  = 1'b1
    } out_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of mask at or after start, wrapping around.
// Works on a doubled copy of the mask so the wrap needs no second search.
module rr_pick
    import ring_pkg::*;
(
    input  logic [BUFFER_SIZE-1:0] mask,
    input  logic [PTR_LEN-1:0]     start,
    output logic [PTR_LEN-1:0]     sel,
    output logic                   found
);

    logic [2*BUFFER_SIZE-1:0] dbl;
    logic [BUFFER_SIZE-1:0]   rot;
    logic [PTR_LEN-1:0]       ofs;

    always_comb begin
        dbl   = {mask, mask} >> start;
        rot   = dbl[BUFFER_SIZE-1:0];
        ofs   = '0;
        found = 1'b0;
        // Descending scan so the lowest offset from start wins.
        for (int i = BUFFER_SIZE - 1; i >= 0; i--) begin
            if (rot[i]) begin
                ofs   = PTR_LEN'(i);
                found = 1'b1;
            end
        end
        sel = start + ofs;
    end

endmodule

// File: rtl/ring_buffer_drain.sv
// Reader side of the router slot buffer: picks occupied slots round-robin, registers
// the packet onto a valid/ready channel and tells the owner which slot to free.
module ring_buffer_drain
    import ring_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  packet_t                buffer [BUFFER_SIZE],
    output packet_t                out_packet,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   clear_en,
    output logic [PTR_LEN-1:0]     clear_pos,
    output logic [PTR_LEN:0]       occupancy
);

    out_state_t             state, state_nxt;
    logic [PTR_LEN-1:0]     rr_ptr;
    logic [BUFFER_SIZE-1:0] occ_mask;
    logic [PTR_LEN-1:0]     sel;
    logic                   found;
    logic                   take;

    always_comb begin
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            occ_mask[i] = buffer[i][VALID_BIT];
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            occupancy = occupancy + {{PTR_LEN{1'b0}}, occ_mask[i]};
        end
    end

    rr_pick u_pick (
        .mask  (occ_mask),
        .start (rr_ptr),
        .sel   (sel),
        .found (found)
    );

    assign out_valid = (state == OUT_HOLD);
    // out_ready feeds straight into take so a held packet can be replaced in one cycle.
    assign take      = rst_n && found && (!out_valid || out_ready);
    assign clear_en  = take;
    assign clear_pos = rst_n ? sel : '0;

    always_comb begin
        state_nxt = state;
        if (take) begin
            state_nxt = OUT_HOLD;
        end else if (state == OUT_HOLD && out_ready) begin
            state_nxt = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= OUT_EMPTY;
            out_packet <= '0;
            rr_ptr     <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                out_packet <= buffer[sel];
                rr_ptr     <= sel + PTR_LEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_ring_buffer_drain.sv
// Self-checking bench for ring_buffer_drain: vector table, directed corner cases
// and a randomized full-buffer run against a slot-level reference model.
module tb_ring_buffer_drain;
    import ring_pkg::*;

    localparam int N = BUFFER_SIZE;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               out_ready = 1'b0;
    packet_t            slots [N];
    packet_t            out_packet;
    logic               out_valid;
    logic               clear_en;
    logic [PTR_LEN-1:0] clear_pos;
    logic [PTR_LEN:0]   occupancy;

    ring_buffer_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buffer     (slots),
        .out_packet (out_packet),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clear_en   (clear_en),
        .clear_pos  (clear_pos),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    int      checks = 0;
    int      errors = 0;
    bit      m_valid = 1'b0;
    packet_t m_pkt = '0;
    int      m_ptr = 0;
    int      tag = 1;
    packet_t exp_q [$];
    packet_t got_q [$];

    typedef struct {
        logic [3:0] mask;
        int         occ;
        bit         ce;
        int         pos;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic packet_t mk(input int slot, input int t);
        logic [15:0] t16;
        t16 = t[15:0];
        return {1'b1, t16, 32'(slot)};
    endfunction

    function automatic packet_t fresh(input int slot);
        packet_t p;
        p = mk(slot, tag);
        tag++;
        return p;
    endfunction

    // One clock: check outputs against the model before the edge, then apply the
    // owner's clear and an optional writer fill at the edge.
    task automatic tick(input bit wr, input int wslot, input packet_t wpkt);
        int cnt;
        int sel;
        bit fnd;
        bit take;
        bit ce;
        int cp;
        @(negedge clk);
        cnt = 0;
        fnd = 1'b0;
        sel = 0;
        for (int i = 0; i < N; i++) begin
            if (slots[i][VALID_BIT]) cnt++;
        end
        for (int k = 0; k < N; k++) begin
            if (!fnd && slots[(m_ptr + k) % N][VALID_BIT]) begin
                fnd = 1'b1;
                sel = (m_ptr + k) % N;
            end
        end
        take = rst_n && fnd && (!m_valid || out_ready);
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_packet", 64'(out_packet), 64'(m_pkt));
        chk("clear_en", 64'(clear_en), 64'(take));
        chk("occupancy", 64'(occupancy), 64'(cnt));
        if (!rst_n) chk("clear_pos_rst", 64'(clear_pos), 64'd0);
        else if (take) chk("clear_pos", 64'(clear_pos), 64'(sel));
        if (rst_n && out_valid && out_ready) got_q.push_back(out_packet);
        if (take) exp_q.push_back(slots[sel]);
        ce = clear_en;
        cp = int'(clear_pos);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_pkt   = '0;
            m_ptr   = 0;
        end else if (take) begin
            m_valid = 1'b1;
            m_pkt   = slots[sel];
            m_ptr   = (sel + 1) % N;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (ce === 1'b1) slots[cp][VALID_BIT] = 1'b0;
        if (wr) slots[wslot] = wpkt;
    endtask

    task automatic t0();
        tick(1'b0, 0, '0);
    endtask

    task automatic clear_slots();
        for (int i = 0; i < N; i++) slots[i] = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        t0();
        t0();
        rst_n = 1'b1;
    endtask

    initial begin
        packet_t p0, p1, p2, p3;
        int bad;
        int s;
        bit wr;

        vecs[0] = '{4'b0000, 0, 1'b0, 0};
        vecs[1] = '{4'b0001, 1, 1'b1, 0};
        vecs[2] = '{4'b0100, 1, 1'b1, 2};
        vecs[3] = '{4'b1010, 2, 1'b1, 1};
        vecs[4] = '{4'b1111, 4, 1'b1, 0};
        vecs[5] = '{4'b1000, 1, 1'b1, 3};
        vecs[6] = '{4'b1100, 2, 1'b1, 2};

        clear_slots();
        #1;

        // Reset held two cycles with slots 0 and 2 occupied
        p0 = fresh(0);
        p2 = fresh(2);
        slots[0] = p0;
        slots[2] = p2;
        rst_n = 1'b0;
        t0();
        t0();
        rst_n = 1'b1;
        out_ready = 1'b1;
        t0();
        chk("t1_valid_after_release", 64'(out_valid), 64'd1);
        chk("t1_slot0", 64'(out_packet), 64'(p0));
        t0();
        t0();

        // Vector table: each entry from a fresh reset, rr_ptr = 0
        foreach (vecs[v]) begin
            do_reset();
            clear_slots();
            for (int i = 0; i < N; i++) begin
                if (vecs[v].mask[i]) slots[i] = fresh(i);
            end
            out_ready = 1'b1;
            #2;
            chk("vec_occupancy", 64'(occupancy), 64'(vecs[v].occ));
            chk("vec_clear_en", 64'(clear_en), 64'(vecs[v].ce));
            if (vecs[v].ce) chk("vec_clear_pos", 64'(clear_pos), 64'(vecs[v].pos));
            t0();
            chk("vec_valid_next", 64'(out_valid), 64'(vecs[v].ce));
        end

        // Round-robin over slots 1 and 3
        do_reset();
        clear_slots();
        p1 = fresh(1);
        p3 = fresh(3);
        slots[1] = p1;
        slots[3] = p3;
        out_ready = 1'b1;
        t0();
        chk("t2_first", 64'(out_packet), 64'(p1));
        t0();
        chk("t2_second", 64'(out_packet), 64'(p3));
        t0();
        chk("t2_rr_ptr", 64'(dut.rr_ptr), 64'd0);

        // Stall with a known packet held for five cycles
        do_reset();
        clear_slots();
        slots[0] = 49'h1_0000_0000_ABCD;
        p1 = fresh(1);
        slots[1] = p1;
        out_ready = 1'b0;
        t0();
        for (int i = 0; i < 5; i++) begin
            t0();
            chk("t3_stall_hold", 64'(out_packet), 64'h1_0000_0000_ABCD);
        end
        out_ready = 1'b1;
        t0();
        chk("t3_release_next", 64'(out_packet), 64'(p1));
        t0();

        // Wrap: drive rr_ptr to 3, then slots 0 and 3
        do_reset();
        clear_slots();
        slots[2] = fresh(2);
        out_ready = 1'b1;
        t0();
        t0();
        chk("t4_rr_ptr3", 64'(dut.rr_ptr), 64'd3);
        p0 = fresh(0);
        p3 = fresh(3);
        slots[0] = p0;
        slots[3] = p3;
        t0();
        chk("t4_slot3_first", 64'(out_packet), 64'(p3));
        t0();
        chk("t4_slot0_second", 64'(out_packet), 64'(p0));
        t0();

        // Writer fills slot 2 on the same edge slot 0 is cleared
        do_reset();
        clear_slots();
        p0 = fresh(0);
        p2 = fresh(2);
        slots[0] = p0;
        out_ready = 1'b1;
        tick(1'b1, 2, p2);
        chk("t5_slot0", 64'(out_packet), 64'(p0));
        t0();
        chk("t5_slot2", 64'(out_packet), 64'(p2));
        t0();
        t0();

        // Full buffer, random backpressure, writer refilling empty slots
        do_reset();
        clear_slots();
        for (int i = 0; i < N; i++) slots[i] = fresh(i);
        exp_q.delete();
        got_q.delete();
        for (int c = 0; c < 1000; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            s = int'($urandom_range(0, N - 1));
            wr = !slots[s][VALID_BIT] && ($urandom_range(0, 1) == 1);
            if (wr) tick(1'b1, s, fresh(s));
            else t0();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) t0();
        chk("t6_count", 64'(got_q.size()), 64'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) bad++;
        end
        chk("t6_order", 64'(bad), 64'd0);
        chk("t6_drained", 64'(occupancy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
